// File: rtl/dab_pkg.sv
// rtl/dab_pkg.sv - shared constants and types for the multi-bridge phase-shift modulator
package dab_pkg;

  localparam int ANG_W       = 9;
  localparam int DT_W        = 8;
  localparam int HALF_PERIOD = 256;
  localparam int QUARTER     = 128;

  // Leg position inside one full bridge
  typedef enum logic {
    LEG_A = 1'b0,
    LEG_B = 1'b1
  } leg_e;

  // Bit position of each switch inside a bridge's 4-bit gate nibble
  typedef enum logic [1:0] {
    G_S4 = 2'd0,
    G_S3 = 2'd1,
    G_S2 = 2'd2,
    G_S1 = 2'd3
  } gate_bit_e;

  // True when a modulo-512 angle lies in the first half period
  function automatic logic in_half(input logic [ANG_W-1:0] x);
    return x < ANG_W'(HALF_PERIOD);
  endfunction

endpackage

// File: rtl/dab_leg_dt.sv
// rtl/dab_leg_dt.sv - one complementary half-bridge leg with rising-edge deadtime
module dab_leg_dt #(
  parameter int DT_W = dab_pkg::DT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            raw,
  input  logic [DT_W-1:0] deadtime,
  output logic            hi,
  output logic            lo
);

  logic            raw_prev;
  logic [DT_W-1:0] cnt;

  // Any toggle drops both switches at once; the new side turns on after the count expires.
  // A toggle during the count restarts it, so the pair can never be on together.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      hi       <= 1'b0;
      lo       <= 1'b0;
      raw_prev <= raw;
      cnt      <= deadtime;
    end else if (raw != raw_prev) begin
      raw_prev <= raw;
      if (deadtime == '0) begin
        hi  <= raw;
        lo  <= !raw;
        cnt <= '0;
      end else begin
        hi  <= 1'b0;
        lo  <= 1'b0;
        cnt <= deadtime;
      end
    end else if (cnt > DT_W'(1)) begin
      cnt <= cnt - DT_W'(1);
    end else begin
      cnt <= '0;
      hi  <= raw_prev;
      lo  <= !raw_prev;
    end
  end

endmodule

// File: rtl/dab_mod_nbridge.sv
// rtl/dab_mod_nbridge.sv - N-bridge phase-shift modulator top; optional DAB_FAULT_LATCH_EN adds a latching fault input
module dab_mod_nbridge #(
  parameter int               N_BR   = 2,
  parameter int               PH_W   = 24,
  parameter int               ANG_W  = dab_pkg::ANG_W,
  parameter int               DT_W   = dab_pkg::DT_W,
  parameter logic [DT_W-1:0]  DT_RST = DT_W'(10)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CE,
  input  logic [PH_W-1:0]       phase_inc,
  input  logic [N_BR*ANG_W-1:0] t_duty,
  input  logic [N_BR*ANG_W-1:0] phi,
  input  logic [DT_W-1:0]       deadtime,
  input  logic                  upd_req,
  output logic                  upd_ack,
  input  logic                  sync,
`ifdef DAB_FAULT_LATCH_EN
  input  logic                  fault,
`endif
  output logic [4*N_BR-1:0]     gate,
  output logic                  trigger,
  output logic                  sat
);

  import dab_pkg::*;

  localparam logic signed [ANG_W:0] PHI_MAX = (ANG_W+1)'(HALF_PERIOD - 1);
  localparam logic signed [ANG_W:0] PHI_MIN = -PHI_MAX;

  logic [PH_W-1:0]   acc;
  logic [PH_W:0]     acc_sum;
  logic              wrap;
  logic              sync_meta, sync_q, sync_d, sync_edge;
  logic              period_start;
  logic              running;
  logic              gate_block;
  logic              leg_en;
  logic [ANG_W-1:0]  theta;
  logic [ANG_W-1:0]  t_sh    [N_BR];
  logic [ANG_W-1:0]  phi_sh  [N_BR];
  logic [ANG_W-1:0]  phi_lim [N_BR];
  logic [N_BR-1:0]   clamp;
  logic [DT_W-1:0]   dt_sh;
  logic [2*N_BR-1:0] raw_d, raw_q, leg_hi, leg_lo;
  logic              unused_phi0;

  // Bridge 0 is the phase reference, so its phi slice has no effect
  assign unused_phi0 = ^phi[ANG_W-1:0];

  assign acc_sum      = {1'b0, acc} + {1'b0, phase_inc};
  assign wrap         = acc_sum[PH_W];
  assign theta        = acc[PH_W-1 -: ANG_W];
  assign sync_edge    = sync_q & ~sync_d;
  assign period_start = CE & (wrap | sync_edge);
  assign leg_en       = CE & running & ~gate_block;

  // Two-flop synchroniser plus one delay flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      sync_d    <= 1'b0;
    end else begin
      sync_meta <= sync;
      sync_q    <= sync_meta;
      sync_d    <= sync_q;
    end
  end

  // Carrier accumulator; a sync edge restarts the period and merges with a coincident wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      trigger <= 1'b0;
      running <= 1'b0;
    end else begin
      trigger <= period_start;
      if (CE) begin
        acc <= sync_edge ? '0 : acc_sum[PH_W-1:0];
      end
      if (period_start) begin
        running <= 1'b1;
      end
    end
  end

  // Clamp each bridge's requested shift so its pulse stays inside bridge 0's window
  always_comb begin
    clamp      = '0;
    phi_lim[0] = '0;
    for (int k = 1; k < N_BR; k++) begin
      logic signed [ANG_W:0] lim;
      logic signed [ANG_W:0] phi_x;
      lim   = $signed({1'b0, t_duty[k*ANG_W +: ANG_W]}) - $signed({1'b0, t_duty[ANG_W-1:0]}) + PHI_MAX;
      phi_x = $signed({phi[k*ANG_W + ANG_W-1], phi[k*ANG_W +: ANG_W]});
      if (phi_x > lim) begin
        phi_lim[k] = lim[ANG_W-1:0];
        clamp[k]   = 1'b1;
      end else if (phi_x < PHI_MIN) begin
        phi_lim[k] = PHI_MIN[ANG_W-1:0];
        clamp[k]   = 1'b1;
      end else begin
        phi_lim[k] = phi[k*ANG_W +: ANG_W];
      end
    end
  end

  // Shadow registers load only at a period start, so a period never mixes old and new settings
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_BR; k++) begin
        t_sh[k]   <= '0;
        phi_sh[k] <= '0;
      end
      dt_sh   <= DT_RST;
      sat     <= 1'b0;
      upd_ack <= 1'b0;
    end else begin
      upd_ack <= period_start & upd_req;
      if (period_start && upd_req) begin
        for (int k = 0; k < N_BR; k++) begin
          t_sh[k]   <= t_duty[k*ANG_W +: ANG_W];
          phi_sh[k] <= phi_lim[k];
        end
        dt_sh <= deadtime;
        sat   <= |clamp;
      end
    end
  end

  // Leg A is high over half a period starting at 128-h; leg B is the same window delayed by 2h
  always_comb begin
    raw_d = '0;
    for (int k = 0; k < N_BR; k++) begin
      raw_d[2*k + int'(LEG_A)] = in_half(theta - phi_sh[k] - ANG_W'(QUARTER) + (t_sh[k] >> 1));
      raw_d[2*k + int'(LEG_B)] = in_half(theta - phi_sh[k] - ANG_W'(QUARTER) - (t_sh[k] >> 1));
    end
  end

  // Compare register: first of the two pipeline stages from theta to the pins
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q <= '0;
    end else begin
      raw_q <= raw_d;
    end
  end

`ifdef DAB_FAULT_LATCH_EN
  logic fault_latch;

  // Once a fault is seen the gates stay off until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_latch <= 1'b0;
    end else if (fault) begin
      fault_latch <= 1'b1;
    end
  end

  assign gate_block = fault | fault_latch;
`else
  assign gate_block = 1'b0;
`endif

  for (genvar k = 0; k < N_BR; k++) begin : g_br
    for (genvar l = 0; l < 2; l++) begin : g_leg
      dab_leg_dt #(.DT_W(DT_W)) u_leg (
        .clk      (clk),
        .rst      (rst),
        .en       (leg_en),
        .raw      (raw_q[2*k + l]),
        .deadtime (dt_sh),
        .hi       (leg_hi[2*k + l]),
        .lo       (leg_lo[2*k + l])
      );
    end
    assign gate[4*k + int'(G_S1)] = leg_hi[2*k + int'(LEG_A)];
    assign gate[4*k + int'(G_S2)] = leg_lo[2*k + int'(LEG_A)];
    assign gate[4*k + int'(G_S3)] = leg_hi[2*k + int'(LEG_B)];
    assign gate[4*k + int'(G_S4)] = leg_lo[2*k + int'(LEG_B)];
  end

endmodule

// File: tb/tb_dab_mod_nbridge.sv
// tb/tb_dab_mod_nbridge.sv - directed bench for dab_mod_nbridge, 2 bridges, 128-clk period
module tb_dab_mod_nbridge;

  logic        clk = 1'b0;
  logic        rst, CE, upd_req, upd_ack, sync, trigger, sat;
  logic [15:0] phase_inc;
  logic [17:0] t_duty, phi;
  logic [7:0]  deadtime;
  logic [7:0]  gate;
`ifdef DAB_FAULT_LATCH_EN
  logic        fault;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int overlap = 0;
  int rise [8];
  int fall [8];
  int pos_start, pos_w, neg_start, neg_w;

  // S4,S3,S2,S1 of bridge 0 then bridge 1; t=255/255, phi_1=64, deadtime=4
  int exp_rise [8] = '{6, 70, 71, 7, 22, 86, 87, 23};
  int exp_fall [8] = '{66, 2, 3, 67, 82, 18, 19, 83};

  always #5 clk = ~clk;

  dab_mod_nbridge #(.N_BR(2), .PH_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .CE        (CE),
    .phase_inc (phase_inc),
    .t_duty    (t_duty),
    .phi       (phi),
    .deadtime  (deadtime),
    .upd_req   (upd_req),
    .upd_ack   (upd_ack),
    .sync      (sync),
`ifdef DAB_FAULT_LATCH_EN
    .fault     (fault),
`endif
    .gate      (gate),
    .trigger   (trigger),
    .sat       (sat)
  );

  // Shoot-through watch on every leg for the whole run
  always @(negedge clk) begin
    if (!rst && ((gate[3] & gate[2]) || (gate[1] & gate[0]) || (gate[7] & gate[6]) || (gate[5] & gate[4])))
      overlap = overlap + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_trig(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (trigger) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Entered on the trigger sample (n=0); returns on sample n=127
  task automatic measure_period();
    logic [7:0] prev;
    prev = gate;
    for (int b = 0; b < 8; b++) begin
      rise[b] = -1;
      fall[b] = -1;
    end
    pos_start = -1; pos_w = 0; neg_start = -1; neg_w = 0;
    for (int n = 1; n < 128; n++) begin
      @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        if (gate[b] && !prev[b] && rise[b] < 0) rise[b] = n;
        if (!gate[b] && prev[b] && fall[b] < 0) fall[b] = n;
      end
      if (gate[3] && gate[0]) begin
        if (pos_start < 0) pos_start = n;
        pos_w++;
      end
      if (gate[2] && gate[1]) begin
        if (neg_start < 0) neg_start = n;
        neg_w++;
      end
      prev = gate;
    end
  endtask

  task automatic load(input logic [17:0] t, input logic [17:0] p, input logic [7:0] dt, input string tag);
    int cyc;
    t_duty = t; phi = p; deadtime = dt; upd_req = 1'b1;
    wait_trig(200, cyc);
    check({tag, "_ack"}, upd_ack, 1);
    upd_req = 1'b0;
  endtask

  initial begin
    int cyc, nz, first, cnt, acc_at, early, ack_at;
    rst = 1'b1; CE = 1'b0; phase_inc = 16'd512; t_duty = '0; phi = '0;
    deadtime = '0; upd_req = 1'b0; sync = 1'b0;
`ifdef DAB_FAULT_LATCH_EN
    fault = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_gate", gate, 0);
    check("rst_trigger", trigger, 0);
    check("rst_ack", upd_ack, 0);
    check("rst_sat", sat, 0);
    check("rst_acc", dut.acc, 0);

    // First load rides on the first period start after reset
    t_duty = {9'd255, 9'd255}; phi = {9'd64, 9'd0}; deadtime = 8'd4;
    upd_req = 1'b1; CE = 1'b1; rst = 1'b0;
    cyc = -1; nz = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (trigger) begin
        cyc = i;
        break;
      end
      if (gate != 0) nz++;
    end
    check("first_trig_cycle", cyc, 128);
    check("first_ack", upd_ack, 1);
    check("first_sat", sat, 0);
    check("gate_before_trig", nz, 0);
    upd_req = 1'b0;
    wait_trig(200, cyc);
    check("period_len", cyc, 128);
    measure_period();
    for (int b = 0; b < 8; b++) begin
      check($sformatf("rise_b%0d", b), rise[b], exp_rise[b]);
      check($sformatf("fall_b%0d", b), fall[b], exp_fall[b]);
    end

    // lim = 128-255+255 = 128 < 200 -> clamped to 128
    load({9'd128, 9'd255}, {9'd200, 9'd0}, 8'd4, "clamp");
    check("clamp_sat", sat, 1);
    wait_trig(200, cyc);
    measure_period();
    check("clamp_s1b1_rise", rise[7], 54);
    check("clamp_s2b1_fall", fall[6], 50);

    load({9'd128, 9'd255}, {9'd100, 9'd0}, 8'd4, "unclamp");
    check("unclamp_sat", sat, 0);
    wait_trig(200, cyc);
    measure_period();
    check("unclamp_s1b1_rise", rise[7], 47);
    check("unclamp_s2b1_fall", fall[6], 43);

    // t_0=128, no deadtime: +1 from 16+2, -1 from 80+2, each 32 clk
    load({9'd255, 9'd128}, 18'd0, 8'd0, "t128");
    wait_trig(200, cyc);
    measure_period();
    check("pos_start", pos_start, 18);
    check("pos_width", pos_w, 32);
    check("neg_start", neg_start, 82);
    check("neg_width", neg_w, 32);

    // sync edge in the middle of a period
    wait_trig(200, cyc);
    check("pre_sync_trig", cyc, 1);
    repeat (32) @(negedge clk);
    check("acc_mid", dut.acc, 16384);
    sync = 1'b1;
    first = -1; acc_at = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (trigger && first < 0) begin
        first = i;
        acc_at = dut.acc;
      end
    end
    check("sync_trig_lat", first, 3);
    check("sync_acc", acc_at, 0);
    sync = 1'b0;

    // sync edge lands in the same cycle as the carrier wrap (now at n=5)
    repeat (120) @(negedge clk);
    sync = 1'b1;
    cnt = 0; first = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (trigger) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    check("wrap_sync_count", cnt, 1);
    check("wrap_sync_pos", first, 3);
    sync = 1'b0;

    // request raised mid-period (now n=5 -> n=64)
    repeat (59) @(negedge clk);
    t_duty = {9'd255, 9'd255}; phi = {9'd64, 9'd0}; deadtime = 8'd4; upd_req = 1'b1;
    cyc = -1; early = 0; ack_at = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (trigger) begin
        cyc = i;
        ack_at = upd_ack;
        break;
      end
      if (upd_ack) early++;
    end
    upd_req = 1'b0;
    check("mid_req_trig", cyc, 64);
    check("mid_req_early_ack", early, 0);
    check("mid_req_ack", ack_at, 1);

    // clock enable low for 10 cycles at n=40
    repeat (40) @(negedge clk);
    check("ce_pre_s1", gate[3], 1);
    CE = 1'b0;
    nz = 0; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gate != 0) nz++;
      if (trigger) cnt++;
    end
    check("ce_gate", nz, 0);
    check("ce_trig", cnt, 0);
    check("ce_acc", dut.acc, 20480);
    CE = 1'b1;
    wait_trig(200, cyc);
    check("ce_resume", cyc, 88);

`ifdef DAB_FAULT_LATCH_EN
    repeat (10) @(negedge clk);
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    check("fault_gate", gate, 0);
    nz = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (gate != 0) nz++;
    end
    check("fault_hold", nz, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load({9'd255, 9'd255}, {9'd64, 9'd0}, 8'd4, "post_fault");
    wait_trig(200, cyc);
    repeat (10) @(negedge clk);
    check("post_fault_s1", gate[3], 1);
`endif

    check("overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
